// File: rtl/alu_pkg.sv
// Shared definitions for the bit-serial ALU: control-word constants,
// Op field encodings and the sequencing state type.
package alu_pkg;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_NOR = 4'b1100;

    localparam logic [1:0] OP_AND = 2'b00;
    localparam logic [1:0] OP_OR  = 2'b01;
    localparam logic [1:0] OP_ADD = 2'b10;
    localparam logic [1:0] OP_SLT = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_e;

endpackage

// File: rtl/alu_bit_slice.sv
// One-bit ALU slice: optional operand inversion, full adder, and Op mux.
// For SLT the slice passes 'less' through; 'set' exposes the raw sum bit.
module alu_bit_slice
    import alu_pkg::*;
(
    input  logic       a_i,
    input  logic       b_i,
    input  logic       less_i,
    input  logic       ainvert_i,
    input  logic       binvert_i,
    input  logic       cin_i,
    input  logic [1:0] op_i,
    output logic       result_o,
    output logic       set_o,
    output logic       cout_o
);

    logic a_s;
    logic b_s;
    logic sum_s;

    assign a_s    = ainvert_i ? ~a_i : a_i;
    assign b_s    = binvert_i ? ~b_i : b_i;
    assign sum_s  = a_s ^ b_s ^ cin_i;
    assign cout_o = (a_s & b_s) | (a_s & cin_i) | (b_s & cin_i);
    assign set_o  = sum_s;

    // Select the slice result by Op field.
    always_comb begin
        result_o = 1'b0;
        case (op_i)
            OP_AND:  result_o = a_s & b_s;
            OP_OR:   result_o = a_s | b_s;
            OP_ADD:  result_o = sum_s;
            OP_SLT:  result_o = less_i;
            default: result_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/serial_alu.sv
// Bit-serial ALU: latches operands, evaluates one bit per clock LSB first
// through a single slice, then presents result and flags until consumed.
module serial_alu
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] src1_i,
    input  logic [WIDTH-1:0] src2_i,
    input  logic [3:0]       ctrl_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] result_o,
    output logic             zero_o,
    output logic             overflow_o,
    output logic             cout_o
);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] src1_q, src1_d;
    logic [WIDTH-1:0] src2_q, src2_d;
    logic [3:0]       ctrl_q, ctrl_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             ovf_q, ovf_d;
    logic             cout_q, cout_d;

    logic slice_res_s;
    logic slice_set_s;
    logic slice_cout_s;
    logic last_s;

    assign last_s = (cnt_q == CNT_W'(WIDTH - 1));

    alu_bit_slice u_slice (
        .a_i       (src1_q[cnt_q]),
        .b_i       (src2_q[cnt_q]),
        .less_i    (1'b0),
        .ainvert_i (ctrl_q[3]),
        .binvert_i (ctrl_q[2]),
        .cin_i     (carry_q),
        .op_i      (ctrl_q[1:0]),
        .result_o  (slice_res_s),
        .set_o     (slice_set_s),
        .cout_o    (slice_cout_s)
    );

    // Next-state logic: handshake sequencing and per-bit result update.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        carry_d  = carry_q;
        src1_d   = src1_q;
        src2_d   = src2_q;
        ctrl_d   = ctrl_q;
        result_d = result_q;
        ovf_d    = ovf_q;
        cout_d   = cout_q;
        case (state_q)
            IDLE: begin
                if (in_valid_i) begin
                    src1_d  = src1_i;
                    src2_d  = src2_i;
                    ctrl_d  = ctrl_i;
                    carry_d = ctrl_i[2];
                    cnt_d   = {CNT_W{1'b0}};
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                carry_d         = slice_cout_s;
                result_d[cnt_q] = slice_res_s;
                if (last_s) begin
                    ovf_d   = ctrl_q[1] ? (carry_q ^ slice_cout_s) : 1'b0;
                    cout_d  = slice_cout_s;
                    state_d = DONE;
                    // SLT: bit 0 becomes the overflow-corrected sign, overriding bit 0's earlier write
                    if (ctrl_q[1:0] == OP_SLT) begin
                        result_d[0] = slice_set_s ^ carry_q ^ slice_cout_s;
                    end else begin
                        result_d[0] = result_d[0];
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DONE: begin
                if (out_ready_i) begin
                    state_d = IDLE;
                end else begin
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers with synchronous reset; reset drops any in-flight op.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            cnt_q    <= {CNT_W{1'b0}};
            carry_q  <= 1'b0;
            src1_q   <= {WIDTH{1'b0}};
            src2_q   <= {WIDTH{1'b0}};
            ctrl_q   <= 4'b0000;
            result_q <= {WIDTH{1'b0}};
            ovf_q    <= 1'b0;
            cout_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            carry_q  <= carry_d;
            src1_q   <= src1_d;
            src2_q   <= src2_d;
            ctrl_q   <= ctrl_d;
            result_q <= result_d;
            ovf_q    <= ovf_d;
            cout_q   <= cout_d;
        end
    end

    assign in_ready_o  = (state_q == IDLE);
    assign out_valid_o = (state_q == DONE);
    assign result_o    = result_q;
    assign zero_o      = (result_q == {WIDTH{1'b0}});
    assign overflow_o  = ovf_q;
    assign cout_o      = cout_q;

endmodule

// File: tb/tb_serial_alu.sv
// Randomized self-checking bench for serial_alu against an arithmetic
// reference model of the ALU control-word semantics.
module tb_serial_alu;
    import alu_pkg::*;

    localparam int W = 32;

    logic         clk_i = 1'b0;
    logic         rst_i;
    logic         in_valid_i;
    logic         in_ready_o;
    logic [W-1:0] src1_i;
    logic [W-1:0] src2_i;
    logic [3:0]   ctrl_i;
    logic         out_valid_o;
    logic         out_ready_i;
    logic [W-1:0] result_o;
    logic         zero_o;
    logic         overflow_o;
    logic         cout_o;

    int chk_cnt  = 0;
    int pass_cnt = 0;

    serial_alu #(.WIDTH(W)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .src1_i      (src1_i),
        .src2_i      (src2_i),
        .ctrl_i      (ctrl_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .result_o    (result_o),
        .zero_o      (zero_o),
        .overflow_o  (overflow_o),
        .cout_o      (cout_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        chk_cnt++;
        if (obs === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: two's-complement arithmetic on the (optionally inverted) operands.
    task automatic model(input logic [W-1:0] a, input logic [W-1:0] b, input logic [3:0] c,
                         output logic [W-1:0] r, output logic ovf, output logic co);
        logic [W-1:0] ap;
        logic [W-1:0] bp;
        logic [W:0]   usum;
        longint       ssum;
        ap   = c[3] ? ~a : a;
        bp   = c[2] ? ~b : b;
        usum = {1'b0, ap} + {1'b0, bp} + {{W{1'b0}}, c[2]};
        ssum = longint'($signed(ap)) + longint'($signed(bp)) + longint'(c[2]);
        co   = usum[W];
        ovf  = c[1] && ((ssum > 64'sd2147483647) || (ssum < -64'sd2147483648));
        case (c[1:0])
            2'b00:   r = ap & bp;
            2'b01:   r = ap | bp;
            2'b10:   r = usum[W-1:0];
            default: r = (ssum < 64'sd0) ? 32'd1 : 32'd0;
        endcase
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic [3:0] c,
                          input bit hold_valid, input int stall);
        logic [W-1:0] er;
        logic         eo;
        logic         ec;
        int           cyc;
        model(a, b, c, er, eo, ec);
        cyc = 0;
        while (!in_ready_o && cyc < 100) begin
            tick();
            cyc++;
        end
        check("in_ready_before_issue", {63'd0, in_ready_o}, 64'd1);
        in_valid_i = 1'b1;
        src1_i     = a;
        src2_i     = b;
        ctrl_i     = c;
        tick();
        if (!hold_valid) in_valid_i = 1'b0;
        check("in_ready_in_run", {63'd0, in_ready_o}, 64'd0);
        cyc = 0;
        while (!out_valid_o && cyc < 100) begin
            if (hold_valid) begin
                src1_i = $urandom;
                src2_i = $urandom;
            end
            tick();
            cyc++;
        end
        in_valid_i = 1'b0;
        check("latency", 64'(cyc), 64'd32);
        check("result", {32'd0, result_o}, {32'd0, er});
        check("zero", {63'd0, zero_o}, {63'd0, (er == 32'd0)});
        check("overflow", {63'd0, overflow_o}, {63'd0, eo});
        check("cout", {63'd0, cout_o}, {63'd0, ec});
        check("in_ready_in_done", {63'd0, in_ready_o}, 64'd0);
        for (int i = 0; i < stall; i++) tick();
        if (stall > 0) begin
            check("stall_valid", {63'd0, out_valid_o}, 64'd1);
            check("stall_result", {32'd0, result_o}, {32'd0, er});
        end
        out_ready_i = 1'b1;
        tick();
        out_ready_i = 1'b0;
        check("valid_drop", {63'd0, out_valid_o}, 64'd0);
        check("ready_after_pop", {63'd0, in_ready_o}, 64'd1);
    endtask

    initial begin
        logic [3:0] codes [6];
        logic [3:0] c;
        codes[0] = ALU_AND; codes[1] = ALU_OR;  codes[2] = ALU_ADD;
        codes[3] = ALU_SUB; codes[4] = ALU_SLT; codes[5] = ALU_NOR;

        rst_i       = 1'b1;
        in_valid_i  = 1'b0;
        out_ready_i = 1'b0;
        src1_i      = 32'd0;
        src2_i      = 32'd0;
        ctrl_i      = 4'b0000;
        tick();
        tick();
        rst_i = 1'b0;
        check("rst_in_ready", {63'd0, in_ready_o}, 64'd1);
        check("rst_out_valid", {63'd0, out_valid_o}, 64'd0);
        check("rst_result", {32'd0, result_o}, 64'd0);
        check("rst_overflow", {63'd0, overflow_o}, 64'd0);
        check("rst_cout", {63'd0, cout_o}, 64'd0);

        run_op(32'd7, 32'd5, ALU_ADD, 1'b0, 0);
        run_op(32'h8000_0000, 32'd1, ALU_SUB, 1'b0, 0);
        run_op(32'hFFFF_FFFF, 32'd1, ALU_SLT, 1'b0, 0);
        run_op(32'h7FFF_FFFF, 32'h8000_0000, ALU_SLT, 1'b0, 0);
        run_op(32'd0, 32'd0, ALU_NOR, 1'b0, 0);
        run_op(32'hF0F0_F0F0, 32'h0F0F_0F0F, ALU_AND, 1'b0, 0);
        run_op(32'h1234_5678, 32'h0000_FFFF, ALU_OR, 1'b1, 5);

        // Reset in the middle of an operation, after ten bits are done.
        in_valid_i = 1'b1;
        src1_i     = 32'h55;
        src2_i     = 32'h33;
        ctrl_i     = ALU_ADD;
        tick();
        in_valid_i = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        check("midrst_out_valid", {63'd0, out_valid_o}, 64'd0);
        check("midrst_in_ready", {63'd0, in_ready_o}, 64'd1);
        run_op(32'd1, 32'd1, ALU_ADD, 1'b0, 0);

        for (int n = 0; n < 40; n++) begin
            if (n % 5 == 4) c = 4'($urandom_range(15, 0));
            else            c = codes[$urandom_range(5, 0)];
            run_op($urandom, $urandom, c, (n % 7 == 3), (n % 6 == 2) ? 3 : 0);
        end

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/serial_alu.md
Name: serial_alu

Overview:
- Bit-serial, multi-cycle ALU for the area-reduced datapath.
- Latches two WIDTH-bit operands and a 4-bit ALU control word, then evaluates one bit per clock, LSB first, through a single 1-bit ALU slice.
- Produces the full result plus zero, overflow and carry flags.
- Uses valid/ready handshakes on both the operand side and the result side, so it can sit behind the ID/EX stage in a stalling pipeline.

Parameters:
- WIDTH, 32, operand/result width in bits; must be >= 2.
- CNT_W, $clog2(WIDTH), width of the bit-position counter.

Ports:
- clk_i  input  1  clock; all state changes on rising edge.
- rst_i  input  1  synchronous reset, active-high.
- in_valid_i  input  1  operands and control are valid.
- in_ready_o  output  1  block can accept operands.
- src1_i  input  WIDTH  operand A.
- src2_i  input  WIDTH  operand B.
- ctrl_i  input  4  {Ainvert, Binvert, Op[1:0]}; Op 00=AND, 01=OR, 10=ADD, 11=SLT.
- out_valid_o  output  1  result and flags are valid.
- out_ready_i  input  1  consumer takes the result.
- result_o  output  WIDTH  ALU result.
- zero_o  output  1  result_o == 0.
- overflow_o  output  1  signed overflow (ADD/SUB only).
- cout_o  output  1  carry out of the MSB.

Behaviour:
- Reset (rst_i=1 at an edge), regardless of state:
  - state=IDLE, counter=0, carry=0.
  - result_o=0, overflow_o=0, cout_o=0, out_valid_o=0.
  - in_ready_o=1 in the cycle after reset.
  - An in-flight operation is discarded with no output.
- States:
  - IDLE:
    - in_ready_o=1, out_valid_o=0.
    - On in_valid_i && in_ready_o, latch src1/src2/ctrl; carry <= Binvert; counter <= 0; state -> RUN.
  - RUN:
    - in_ready_o=0; in_valid_i is ignored.
    - Each edge evaluates bit k=counter:
      - a' = Ainvert ? ~A[k] : A[k]; b' = Binvert ? ~B[k] : B[k].
      - sum = a'^b'^carry; carry <= majority(a', b', carry).
      - result[k] <= Op==00 ? a'&b' : Op==01 ? a'|b' : Op==10 ? sum : 0.
    - On k=WIDTH-1:
      - overflow_o <= (Op==10 || Op==11) ? (carry_in ^ carry_out) : 0.
      - cout_o <= carry_out.
      - If Op==11, result[0] <= sum ^ (carry_in ^ carry_out), i.e. set corrected for overflow.
      - state -> DONE.
  - DONE:
    - out_valid_o=1; result_o, flags and zero_o are stable.
    - On out_ready_i: state -> IDLE, out_valid_o drops the next cycle.
    - No same-cycle re-accept: in_ready_o=0 while in DONE.
- Latency and throughput:
  - out_valid_o rises exactly WIDTH cycles after the accepting edge.
  - Minimum issue interval is WIDTH+2 cycles.
- Output timing:
  - zero_o is combinational from result_o; it is only meaningful while out_valid_o=1.
  - result_o holds its last value outside DONE; it is not cleared.
- Decoded operations: AND=0000, OR=0001, ADD=0010, SUB=0110, SLT=0111, NOR=1100. Any other code evaluates generically per field.
- Backpressure: out_ready_i low holds DONE indefinitely with outputs frozen.
- Bit-slice ordering: result bit 0 is written at cycle 0 and, for SLT, overwritten at cycle WIDTH-1; the overwrite must take precedence.

Decomposition:
- Shared package alu_pkg holds:
  - ALU control constants (ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_SLT, ALU_NOR).
  - Op field encodings.
  - The state enum (IDLE, RUN, DONE).
- One natural sub-module: alu_bit_slice.
  - Combinational 1-bit slice taking a, b, less, ainvert, binvert, cin, op.
  - Outputs result, set, cout.
  - Instantiated once and fed by the counter-indexed operand bits.
- The FSM, counter, carry register and result shift/index logic stay in serial_alu.

Test Plan:
- ADD: src1=7, src2=5, ctrl=0010.
  - result_o=12, overflow_o=0, zero_o=0, cout_o=0.
  - out_valid_o rises exactly 32 cycles after acceptance.
- SUB overflow: src1=0x80000000, src2=1, ctrl=0110.
  - result_o=0x7FFFFFFF, overflow_o=1, cout_o=1.
- SLT with overflow correction:
  - src1=0xFFFFFFFF, src2=1, ctrl=0111 -> result_o=1.
  - src1=0x7FFFFFFF, src2=0x80000000 -> result_o=0, overflow_o=1.
- NOR/zero:
  - src1=0, src2=0, ctrl=1100 -> result_o=0xFFFFFFFF, zero_o=0.
  - AND with src1=0xF0F0F0F0, src2=0x0F0F0F0F -> result_o=0, zero_o=1.
- Handshake:
  - in_valid_i held high during RUN is not re-accepted.
  - out_ready_i low for 5 cycles: out_valid_o and result_o stay stable.
  - After out_ready_i pulses, in_ready_o=1 on the next cycle.
- Reset mid-operation: assert rst_i at counter=10.
  - Next cycle: IDLE, out_valid_o=0, in_ready_o=1.
  - A new ADD 1+1 then completes with result_o=2.
